// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and pointer type
package fifo_pkg;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef logic [ADDR_WIDTH:0] ptr_t;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer with wrap bit, advances by one on inc
module fifo_ptr #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [ADDR_WIDTH:0]   ptr
);
    always_ff @(posedge clk)
        ptr <= !rst_n ? '0 : ptr + {{ADDR_WIDTH{1'b0}}, inc};
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: push/pop FIFO controller for an external dual-port memory; FIFO_CTRL_ERR_EN adds sticky overflow/underflow
module fifo_ctrl #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic push_ok, pop_ok;
    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr (.clk(clk), .rst_n(rst_n), .inc(push_ok), .ptr(wr_ptr));
    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd (.clk(clk), .rst_n(rst_n), .inc(pop_ok), .ptr(rd_ptr));
    always_comb begin
        empty      = wr_ptr == rd_ptr;
        full       = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
        count      = wr_ptr - rd_ptr;
        push_ok    = push && !full;
        pop_ok     = pop && !empty;
        mem_w_en   = push_ok;
        mem_w_addr = push_ok ? wr_ptr[ADDR_WIDTH-1:0] : '0;
        mem_w_data = push_ok ? din : '0;
        mem_r_en   = pop_ok;
        mem_r_addr = pop_ok ? rd_ptr[ADDR_WIDTH-1:0] : '0;
        rd_data    = mem_r_data;
    end
    always_ff @(posedge clk)
        rd_valid <= rst_n && pop_ok;
`ifdef FIFO_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        overflow  <= rst_n && (overflow || (push && full));
        underflow <= rst_n && (underflow || (pop && empty));
    end
`endif
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the 16 x 8 dual-port `memory` block. It turns a push/pop interface into the memory's `w_en`/`w_addr`/`w_data` and `r_en`/`r_addr` strobes. It tracks occupancy with wrap-around pointers and returns popped data from the memory's registered `r_data`. Producers and consumers in the design use this block and never address the RAM directly.

## Interface
- `ADDR_WIDTH`, 4: memory address width; depth = 2**ADDR_WIDTH (16).
- `DATA_WIDTH`, 8: data word width; matches the memory.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `push`  in  1  write request for this cycle.
- `din`  in  DATA_WIDTH  data to write; sampled with `push`.
- `pop`  in  1  read request for this cycle.
- `rd_data`  out  DATA_WIDTH  popped word; wired from `mem_r_data`.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `full`  out  1  occupancy == depth.
- `empty`  out  1  occupancy == 0.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..depth.
- `mem_w_en`, `mem_w_addr[ADDR_WIDTH]`, `mem_w_data[DATA_WIDTH]`  out  memory write port.
- `mem_r_en`, `mem_r_addr[ADDR_WIDTH]`  out  memory read port.
- `mem_r_data`  in  DATA_WIDTH  memory registered read data.

## Operation
- Pointers: `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits each. The low ADDR_WIDTH bits address the memory; the MSB is the wrap bit.
- `empty` = pointers equal. `full` = low bits equal and MSBs differ.
- Push accepted = `push & ~full`. It drives `mem_w_en=1`, `mem_w_addr=wr_ptr[ADDR_WIDTH-1:0]`, `mem_w_data=din` combinationally in the same cycle. `wr_ptr` increments at the edge.
- Pop accepted = `pop & ~empty`. It drives `mem_r_en=1` and `mem_r_addr=rd_ptr[ADDR_WIDTH-1:0]` in the same cycle. `rd_ptr` increments at the edge.
- `count` changes as follows: +1 on push only, -1 on pop only, unchanged on both or neither.
- Rejected requests (push when full, pop when empty) are dropped silently. No pointer, count, or memory strobe changes.
- Push and pop in the same cycle:
  - When empty: push accepted, pop rejected. There is no fall-through.
  - When full: pop accepted, push rejected.
  - Otherwise: both accepted, count unchanged.
- Memory read and write addresses never collide, because an accepted pop requires non-empty and an accepted push requires non-full.
- Pointer wrap: after `1_1111` comes `0_0000`. A wrap is legal at any occupancy.

## Timing
- Reset (`rst_n=0` at a rising edge): `wr_ptr=rd_ptr=0`, `count=0`, `empty=1`, `full=0`, `rd_valid=0`. All `mem_*` strobes are 0 whenever no request is accepted.
- Memory contents are not cleared by reset. Data in flight is discarded.
- If reset is asserted mid-stream, `rd_valid` is 0 in the cycle after the reset edge, even if a pop was accepted in the cycle before it.
- Write latency: a word pushed at edge N is poppable from edge N+1, i.e. `empty` deasserts after edge N.
- Read latency: a pop accepted in cycle N gives `rd_valid=1` in cycle N+1, with `rd_data` = memory `r_data` registered at edge N. `rd_valid` is a register.
- Back-to-back pops give one valid word per cycle.
- `full`, `empty`, and `count` are registered or derived purely from registers. They never depend combinationally on `push` or `pop`.

## Configuration
- Macro: `FIFO_CTRL_ERR_EN`.
- Defined: adds outputs `overflow` and `underflow` (1 bit each).
  - `overflow` is sticky-set on a rejected push (`push & full`).
  - `underflow` is sticky-set on a rejected pop (`pop & empty`).
  - Both clear only on reset.
- Undefined: these ports and registers do not exist. Rejected requests remain silently ignored.

## Structure
- Shared package `fifo_pkg` holds:
  - default `ADDR_WIDTH`/`DATA_WIDTH` constants;
  - the `DEPTH = 1 << ADDR_WIDTH` constant;
  - a pointer typedef (ADDR_WIDTH+1 bits).
- Sub-module `fifo_ptr` is instantiated twice (write and read).
  - Inputs: `clk`, `rst_n`, `inc`.
  - Output: wrapping pointer.
- The top level owns the flag, count, and `rd_valid` logic plus the memory strobes.
- The `memory` instance sits in the parent. This block exposes the `mem_*` ports only.

## Test plan
- Reset, then idle 4 cycles -> `empty=1`, `full=0`, `count=0`, no `mem_w_en`/`mem_r_en`, `rd_valid=0`.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 -> `rd_valid` on 3 consecutive cycles, each one cycle after its pop, with `rd_data` = 0x11, 0x22, 0x33. `empty=1` after the third pop.
- Push 16 words 0xA0..0xAF -> `full=1`, `count=16`. A 17th push of 0xFF -> no `mem_w_en`, `count=16`, and `overflow=1` when `FIFO_CTRL_ERR_EN` is defined. Then pop 16 -> 0xA0..0xAF in order.
- Wrap: push/pop 20 words in a streaming pattern -> `mem_w_addr` sequence 0..15, 0..3. Data order is preserved and `count` never exceeds 16.
- Simultaneous push+pop:
  - At `count=5` -> both accepted, `count` stays 5.
  - At empty with `din=0x5A` -> `count=1`, `rd_valid=0` next cycle.
  - At full -> `count=15`.
- Pop while empty -> no `mem_r_en`, `rd_valid=0`, and `underflow=1` when the macro is defined. Reset mid-stream at `count=7` -> `count=0`, `empty=1`, `rd_valid=0` next cycle.
